// File: rtl/clock_mode_fsm_pkg.sv
// rtl/clock_mode_fsm_pkg.sv - shared mode type and decode helpers for the clock mode controller
package clock_pkg;

  typedef enum logic {MODE_VIEW = 1'b0, MODE_SET = 1'b1} mode_e;

  localparam int unsigned ONEHOT_MAX = 32;

  // One-hot decode of idx into a vector of `width` meaningful bits (upper bits zero).
  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx, input int unsigned width);
    logic [ONEHOT_MAX-1:0] v;
    v = '0;
    if (idx < width) v = ONEHOT_MAX'(1) << idx;
    return v;
  endfunction

  // Index counter width; a single-entry counter still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_mode_fsm_if.sv
// rtl/clock_mode_fsm_if.sv - key/tick inputs and mode/select outputs of the clock mode controller
interface clock_mode_fsm_if #(
  parameter int unsigned N_VIEWS  = 2,
  parameter int unsigned N_DIGITS = 6
);

  logic                tick;
  logic                key_short;
  logic                key_long;
  logic [N_VIEWS-1:0]  view_sel;
  logic [N_DIGITS-1:0] digit_sel;
  logic                set_active;
  logic                blink;
  logic                commit;
  logic                abort;
  logic                timeout;
  logic                state;

  modport master (
    output tick, key_short, key_long,
    input  view_sel, digit_sel, set_active, blink, commit, abort, timeout, state
  );

  modport slave (
    input  tick, key_short, key_long,
    output view_sel, digit_sel, set_active, blink, commit, abort, timeout, state
  );

endinterface

// File: rtl/clock_mode_fsm_tick_timeout.sv
// rtl/clock_mode_fsm_tick_timeout.sv - counts tick pulses and flags the LIMIT-th one
module tick_timeout #(
  parameter int unsigned LIMIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam int unsigned    CW   = $clog2(LIMIT + 1);
  localparam logic [CW-1:0]  LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_hit;

  // clr dominates: a tick coinciding with clr never expires
  assign w_hit   = tick && !clr && (r_cnt == LAST);
  assign expired = w_hit;

  // Tick counter, restarts on clear or on expiry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || w_hit) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clock_mode_fsm.sv
// rtl/clock_mode_fsm.sv - view/set mode controller with inactivity timeout and digit blink
module clock_mode_fsm
  import clock_pkg::*;
#(
  parameter int unsigned N_VIEWS       = 2,
  parameter int unsigned N_DIGITS      = 6,
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter int unsigned BLINK_TICKS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  clock_mode_fsm_if.slave  bus
);

  localparam logic [0:0]    ST_VIEW    = 1'(MODE_VIEW);
  localparam logic [0:0]    ST_SET     = 1'(MODE_SET);
  localparam int unsigned   VW         = idx_width(N_VIEWS);
  localparam int unsigned   DW         = idx_width(N_DIGITS);
  localparam logic [VW-1:0] LAST_VIEW  = VW'(N_VIEWS - 1);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(N_DIGITS - 1);

  logic [0:0]          r_mode;
  logic [VW-1:0]       r_view_idx;
  logic [DW-1:0]       r_digit_idx;
  logic                r_blink;
  logic [N_VIEWS-1:0]  r_view_sel;
  logic [N_DIGITS-1:0] r_digit_sel;
  logic                r_commit;
  logic                r_abort;
  logic                r_timeout;

  logic                w_key;
  logic                w_to_exp;
  logic                w_blink_exp;
  logic                w_blink_clr;
  logic [0:0]          w_mode_nx;
  logic [VW-1:0]       w_view_nx;
  logic [DW-1:0]       w_digit_nx;
  logic                w_blink_nx;
  logic                w_commit_nx;
  logic                w_abort_nx;
  logic                w_timeout_nx;
  logic [ONEHOT_MAX-1:0] w_view_oh_full;
  logic [ONEHOT_MAX-1:0] w_digit_oh_full;
  logic                w_unused_oh;

  assign w_key = bus.key_short | bus.key_long;

  // Any key restarts the inactivity window; timeout-driven exits clear it by expiring.
  tick_timeout #(.LIMIT(TIMEOUT_TICKS)) u_idle (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_key),
    .tick    (bus.tick),
    .expired (w_to_exp)
  );

  // Blink divider only runs in SET; keys restart the half-period.
  assign w_blink_clr = (r_mode == ST_VIEW) | w_key;

  tick_timeout #(.LIMIT(BLINK_TICKS)) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_blink_clr),
    .tick    (bus.tick),
    .expired (w_blink_exp)
  );

  // Next mode, indices, blink phase and event pulses; key_long beats key_short, keys beat timeout
  always_comb begin
    w_mode_nx    = r_mode;
    w_view_nx    = r_view_idx;
    w_digit_nx   = r_digit_idx;
    w_blink_nx   = r_blink;
    w_commit_nx  = 1'b0;
    w_abort_nx   = 1'b0;
    w_timeout_nx = 1'b0;
    if (r_mode == ST_VIEW) begin
      if (bus.key_long) begin
        w_mode_nx  = ST_SET;
        w_digit_nx = '0;
        w_blink_nx = 1'b1;
      end else if (bus.key_short) begin
        w_view_nx = (r_view_idx == LAST_VIEW) ? '0 : r_view_idx + 1'b1;
      end else if (w_to_exp) begin
        w_timeout_nx = 1'b1;
        w_view_nx    = '0;
      end
    end else begin
      if (bus.key_long) begin
        w_mode_nx  = ST_VIEW;
        w_view_nx  = '0;
        w_digit_nx = '0;
        w_blink_nx = 1'b0;
        w_abort_nx = 1'b1;
      end else if (bus.key_short) begin
        if (r_digit_idx != LAST_DIGIT) begin
          w_digit_nx = r_digit_idx + 1'b1;
          w_blink_nx = 1'b1;
        end else begin
          w_mode_nx   = ST_VIEW;
          w_view_nx   = '0;
          w_digit_nx  = '0;
          w_blink_nx  = 1'b0;
          w_commit_nx = 1'b1;
        end
      end else if (w_to_exp) begin
        w_mode_nx    = ST_VIEW;
        w_view_nx    = '0;
        w_digit_nx   = '0;
        w_blink_nx   = 1'b0;
        w_abort_nx   = 1'b1;
        w_timeout_nx = 1'b1;
      end else if (w_blink_exp) begin
        w_blink_nx = ~r_blink;
      end
    end
  end

  assign w_view_oh_full  = onehot(32'(w_view_nx), N_VIEWS);
  assign w_digit_oh_full = onehot(32'(w_digit_nx), N_DIGITS);
  assign w_unused_oh     = ^{w_view_oh_full, w_digit_oh_full};

  // Mode/index state and registered one-hot select outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode      <= ST_VIEW;
      r_view_idx  <= '0;
      r_digit_idx <= '0;
      r_blink     <= 1'b0;
      r_view_sel  <= N_VIEWS'(1);
      r_digit_sel <= '0;
      r_commit    <= 1'b0;
      r_abort     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_mode      <= w_mode_nx;
      r_view_idx  <= w_view_nx;
      r_digit_idx <= w_digit_nx;
      r_blink     <= w_blink_nx;
      r_view_sel  <= (w_mode_nx == ST_VIEW) ? w_view_oh_full[N_VIEWS-1:0] : '0;
      r_digit_sel <= (w_mode_nx == ST_SET) ? w_digit_oh_full[N_DIGITS-1:0] : '0;
      r_commit    <= w_commit_nx;
      r_abort     <= w_abort_nx;
      r_timeout   <= w_timeout_nx;
    end
  end

  assign bus.view_sel   = r_view_sel;
  assign bus.digit_sel  = r_digit_sel;
  assign bus.set_active = (r_mode == ST_SET);
  assign bus.blink      = r_blink;
  assign bus.commit     = r_commit;
  assign bus.abort      = r_abort;
  assign bus.timeout    = r_timeout;
  assign bus.state      = r_mode[0];

endmodule

// File: tb/tb_clock_mode_fsm.sv
// tb/tb_clock_mode_fsm.sv - self-checking bench for clock_mode_fsm
module tb_clock_mode_fsm;

  localparam int NV = 2;
  localparam int ND = 6;
  localparam int TO = 10;
  localparam int BT = 1;

  logic clk;
  logic rst_n;
  logic rst1_n;
  int   total;
  int   bad;

  clock_mode_fsm_if #(.N_VIEWS(NV), .N_DIGITS(ND)) bus0 ();
  clock_mode_fsm_if #(.N_VIEWS(1), .N_DIGITS(1)) bus1 ();

  clock_mode_fsm #(.N_VIEWS(NV), .N_DIGITS(ND), .TIMEOUT_TICKS(TO), .BLINK_TICKS(BT)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  clock_mode_fsm #(.N_VIEWS(1), .N_DIGITS(1), .TIMEOUT_TICKS(3), .BLINK_TICKS(2)) dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (integer view of the mode rules) ----------------
  int m_set, m_view, m_digit, m_idle, m_bcnt;
  bit m_blink, m_commit, m_abort, m_to;

  function automatic void model_reset();
    m_set = 0; m_view = 0; m_digit = 0; m_idle = 0; m_bcnt = 0;
    m_blink = 0; m_commit = 0; m_abort = 0; m_to = 0;
  endfunction

  function automatic void model_leave();
    m_set = 0; m_view = 0; m_digit = 0; m_blink = 0;
  endfunction

  function automatic void model_step(input bit ks, input bit kl, input bit tk);
    bit key, fire_to, fire_b;
    key = ks | kl; fire_to = 0; fire_b = 0;
    m_commit = 0; m_abort = 0; m_to = 0;
    if (key) m_idle = 0;
    else if (tk) begin
      m_idle++;
      if (m_idle == TO) begin m_idle = 0; fire_to = 1; end
    end
    if (m_set == 0 || key) m_bcnt = 0;
    else if (tk) begin
      m_bcnt++;
      if (m_bcnt == BT) begin m_bcnt = 0; fire_b = 1; end
    end
    if (m_set == 0) begin
      if (kl) begin m_set = 1; m_digit = 0; m_blink = 1; end
      else if (ks) m_view = (m_view + 1) % NV;
      else if (fire_to) begin m_to = 1; m_view = 0; end
    end else begin
      if (kl) begin model_leave(); m_abort = 1; end
      else if (ks) begin
        if (m_digit < ND - 1) begin m_digit++; m_blink = 1; end
        else begin model_leave(); m_commit = 1; end
      end else if (fire_to) begin model_leave(); m_abort = 1; m_to = 1; end
      else if (fire_b) m_blink = !m_blink;
    end
  endfunction

  function automatic logic [13:0] model_pack();
    logic [1:0] v;
    logic [5:0] d;
    v = (m_set != 0) ? 2'b00 : 2'(1 << m_view);
    d = (m_set != 0) ? 6'(1 << m_digit) : 6'b0;
    return {v, d, 1'(m_set), 1'(m_set) & m_blink, m_commit, m_abort, m_to, 1'(m_set)};
  endfunction

  function automatic logic [13:0] pack0();
    return {bus0.view_sel, bus0.digit_sel, bus0.set_active, bus0.blink,
            bus0.commit, bus0.abort, bus0.timeout, bus0.state};
  endfunction

  function automatic logic [13:0] pack1();
    return 14'({bus1.view_sel, bus1.digit_sel, bus1.set_active, bus1.blink,
                bus1.commit, bus1.abort, bus1.timeout, bus1.state});
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // one clock on dut0 with inputs held across the edge, checked against the model
  task automatic cyc(input bit rn, input bit ks, input bit kl, input bit tk, input string name);
    rst_n = rn; bus0.key_short = ks; bus0.key_long = kl; bus0.tick = tk;
    @(posedge clk); #1;
    rst_n = 1'b1; bus0.key_short = 1'b0; bus0.key_long = 1'b0; bus0.tick = 1'b0;
    if (!rn) model_reset(); else model_step(ks, kl, tk);
    chk(name, pack0(), model_pack());
  endtask

  task automatic cyc1(input bit rn, input bit ks, input bit kl, input bit tk,
                      input string name, input logic [7:0] exp);
    rst1_n = rn; bus1.key_short = ks; bus1.key_long = kl; bus1.tick = tk;
    @(posedge clk); #1;
    rst1_n = 1'b1; bus1.key_short = 1'b0; bus1.key_long = 1'b0; bus1.tick = 1'b0;
    chk(name, pack1(), 14'(exp));
  endtask

  // expected output word: {view_sel, digit_sel, set, blink, commit, abort, timeout, state}
  function automatic logic [13:0] ex(input logic [1:0] v, input logic [5:0] d, input bit s,
                                     input bit b, input bit c, input bit a, input bit t);
    return {v, d, s, b, c, a, t, s};
  endfunction

  typedef struct {
    bit          ks;
    bit          kl;
    bit          tk;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[16];
  int   n_to;
  int   kp;

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; rst1_n = 1'b0;
    bus0.tick = 1'b0; bus0.key_short = 1'b0; bus0.key_long = 1'b0;
    bus1.tick = 1'b0; bus1.key_short = 1'b0; bus1.key_long = 1'b0;
    model_reset();

    tbl[0]  = '{1, 0, 0, ex(2'b10, 6'b000000, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1, 0, 0, ex(2'b01, 6'b000000, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1, 0, 0, ex(2'b10, 6'b000000, 0, 0, 0, 0, 0)};
    tbl[3]  = '{0, 1, 0, ex(2'b00, 6'b000001, 1, 1, 0, 0, 0)};
    tbl[4]  = '{1, 0, 0, ex(2'b00, 6'b000010, 1, 1, 0, 0, 0)};
    tbl[5]  = '{1, 0, 0, ex(2'b00, 6'b000100, 1, 1, 0, 0, 0)};
    tbl[6]  = '{1, 0, 0, ex(2'b00, 6'b001000, 1, 1, 0, 0, 0)};
    tbl[7]  = '{1, 0, 0, ex(2'b00, 6'b010000, 1, 1, 0, 0, 0)};
    tbl[8]  = '{1, 0, 0, ex(2'b00, 6'b100000, 1, 1, 0, 0, 0)};
    tbl[9]  = '{1, 0, 0, ex(2'b01, 6'b000000, 0, 0, 1, 0, 0)};
    tbl[10] = '{0, 0, 0, ex(2'b01, 6'b000000, 0, 0, 0, 0, 0)};
    tbl[11] = '{0, 1, 0, ex(2'b00, 6'b000001, 1, 1, 0, 0, 0)};
    tbl[12] = '{1, 0, 0, ex(2'b00, 6'b000010, 1, 1, 0, 0, 0)};
    tbl[13] = '{1, 0, 0, ex(2'b00, 6'b000100, 1, 1, 0, 0, 0)};
    tbl[14] = '{0, 1, 0, ex(2'b01, 6'b000000, 0, 0, 0, 1, 0)};
    tbl[15] = '{0, 0, 0, ex(2'b01, 6'b000000, 0, 0, 0, 0, 0)};

    // reset state
    cyc(0, 0, 0, 0, "rst_a");
    cyc(0, 1, 1, 1, "rst_b");
    chk("reset_const", pack0(), ex(2'b01, 6'b0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, "release");

    // view cycling, full set/commit, set/abort
    for (int i = 0; i < 16; i++) begin
      cyc(1, tbl[i].ks, tbl[i].kl, tbl[i].tk, $sformatf("model_tbl%0d", i));
      chk($sformatf("tbl%0d", i), pack0(), tbl[i].exp);
    end

    // timeout in SET at digit 2
    cyc(1, 0, 1, 0, "to_kl");
    cyc(1, 1, 0, 0, "to_ks1");
    cyc(1, 1, 0, 0, "to_ks2");
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 1, "to_set_tick");
    cyc(1, 0, 0, 1, "to_set_10");
    chk("to_set_pulse", pack0(), ex(2'b01, 6'b0, 0, 0, 0, 1, 1));

    // timeout in VIEW 1 returns home
    cyc(1, 1, 0, 0, "tv_ks");
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 1, "tv_tick");
    cyc(1, 0, 0, 1, "tv_10");
    chk("to_view1", pack0(), ex(2'b01, 6'b0, 0, 0, 0, 0, 1));

    // key on tick 9 restarts the window
    cyc(1, 1, 0, 0, "tk_ks");
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, "tk_tick");
    cyc(1, 1, 0, 1, "tk_key9");
    chk("key_tick_view", pack0(), ex(2'b01, 6'b0, 0, 0, 0, 0, 0));
    n_to = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1, 0, 0, 1, "tk_wait");
      n_to += int'(bus0.timeout);
    end
    chk("no_early_to", 14'(n_to), 14'(0));
    cyc(1, 0, 0, 1, "tk_10");
    chk("to_view0", pack0(), ex(2'b01, 6'b0, 0, 0, 0, 0, 1));

    // simultaneous keys and key+tick on the 10th tick
    cyc(1, 1, 1, 0, "both_view");
    chk("both_view", pack0(), ex(2'b00, 6'b000001, 1, 1, 0, 0, 0));
    cyc(1, 1, 1, 0, "both_set");
    chk("both_set", pack0(), ex(2'b01, 6'b0, 0, 0, 0, 1, 0));
    cyc(1, 0, 1, 0, "kt_kl");
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 1, "kt_tick");
    cyc(1, 1, 0, 1, "kt_10");
    chk("key_tick_set", pack0(), ex(2'b00, 6'b000010, 1, 1, 0, 0, 0));

    // reset mid-SET at digit 4
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, "rs_ks");
    chk("at_digit4", pack0(), ex(2'b00, 6'b010000, 1, 1, 0, 0, 0));
    cyc(0, 0, 0, 0, "rs_rst");
    chk("rst_mid_set", pack0(), ex(2'b01, 6'b0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, "rs_after");
    chk("rst_no_abort", pack0(), ex(2'b01, 6'b0, 0, 0, 0, 0, 0));

    // randomized traffic, alternating busy and quiet key phases
    for (int i = 0; i < 3000; i++) begin
      bit ks, kl, tk, rn;
      kp = ((i / 400) % 2 == 0) ? 6 : 60;
      ks = ($urandom_range(0, kp - 1) == 0);
      kl = ($urandom_range(0, 2 * kp - 1) == 0);
      tk = ($urandom_range(0, 2) == 0);
      rn = ($urandom_range(0, 499) != 0);
      cyc(rn, ks, kl, tk, "random");
    end

    // single-view, single-digit variant (TIMEOUT 3, BLINK 2): {view,digit,set,blink,c,a,t,state}
    cyc1(0, 0, 0, 0, "v1_rst",    8'b1_0_0_0_0_0_0_0);
    cyc1(1, 0, 0, 0, "v1_idle",   8'b1_0_0_0_0_0_0_0);
    cyc1(1, 1, 0, 0, "v1_ks_nop", 8'b1_0_0_0_0_0_0_0);
    cyc1(1, 0, 1, 0, "v1_set",    8'b0_1_1_1_0_0_0_1);
    cyc1(1, 0, 0, 1, "v1_tick1",  8'b0_1_1_1_0_0_0_1);
    cyc1(1, 0, 0, 1, "v1_tick2",  8'b0_1_1_0_0_0_0_1);
    cyc1(1, 1, 0, 0, "v1_commit", 8'b1_0_0_0_1_0_0_0);
    cyc1(1, 0, 0, 0, "v1_after",  8'b1_0_0_0_0_0_0_0);
    cyc1(1, 0, 1, 0, "v1_set2",   8'b0_1_1_1_0_0_0_1);
    cyc1(1, 0, 0, 1, "v1_t1",     8'b0_1_1_1_0_0_0_1);
    cyc1(1, 0, 0, 1, "v1_t2",     8'b0_1_1_0_0_0_0_1);
    cyc1(1, 0, 0, 1, "v1_t3",     8'b1_0_0_0_0_1_1_0);
    cyc1(1, 0, 0, 0, "v1_end",    8'b1_0_0_0_0_0_0_0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
